// File: rtl/nibble_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_adder_pkg
// Shared constants and types for the nibble-serial adder.
//   NIBBLE_W : width of one digit handled per cycle by the serial datapath
//   state_e  : sequencing states of the serial adder (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// -----------------------------------------------------------------------------
// cla4
// Purely combinational 4-bit carry-lookahead adder.
// Ports:
//   a[3:0], b[3:0] : addend nibbles
//   cin            : carry into bit 0
//   s[3:0]         : sum nibble, (a + b + cin) mod 16
//   cout           : carry out of bit 3
// -----------------------------------------------------------------------------
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] prop;
  logic [3:0] gen;
  logic [4:0] carry;

  // Every carry is expanded directly from generate/propagate terms and cin,
  // so no carry depends on the carry of the bit below it.
  always_comb begin
    prop     = a ^ b;
    gen      = a & b;
    carry[0] = cin;
    carry[1] = gen[0] | (prop[0] & cin);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & cin);
    carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
    s        = prop ^ carry[3:0];
    cout     = carry[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock, LSB nibble
// first, through a single 4-bit carry-lookahead adder. Results are held
// until the consumer takes them.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   in_valid  : a, b, cin are presented
//   in_ready  : high only while idle, operands are captured when both high
//   a, b      : W-bit operands (unsigned or two's complement)
//   cin       : carry into the least significant nibble
//   out_valid : sum, cout, overflow hold a result (DONE state)
//   out_ready : consumer accepts the result
//   sum       : (a + b + cin) mod 2^W
//   cout      : carry out of the most significant nibble
//   overflow  : signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        overflow
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

  state_e          state_q;
  logic [W-1:0]    aOp_q;
  logic [W-1:0]    bOp_q;
  logic [W-1:0]    sumWork_q;
  logic [W-1:0]    sumWork_d;
  logic            carry_q;
  logic [CW-1:0]   count_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            overflow_q;

  logic [NIBBLE_W-1:0] aNib;
  logic [NIBBLE_W-1:0] bNib;
  logic [NIBBLE_W-1:0] nibSum;
  logic                nibCout;
  logic                carryIntoMsb;

  // Select the operand nibbles for the current step and fold the freshly
  // computed nibble into the working sum. The carry into the top bit of the
  // word is recovered from the sum bit, since s = a ^ b ^ c at every bit;
  // it only matters on the final nibble.
  always_comb begin
    aNib         = aOp_q[int'(count_q) * NIBBLE_W +: NIBBLE_W];
    bNib         = bOp_q[int'(count_q) * NIBBLE_W +: NIBBLE_W];
    sumWork_d    = sumWork_q;
    sumWork_d[int'(count_q) * NIBBLE_W +: NIBBLE_W] = nibSum;
    carryIntoMsb = nibSum[NIBBLE_W-1] ^ aNib[NIBBLE_W-1] ^ bNib[NIBBLE_W-1];
  end

  cla4 u_cla4 (
    .a    (aNib),
    .b    (bNib),
    .cin  (carry_q),
    .s    (nibSum),
    .cout (nibCout)
  );

  // Sequencer and datapath registers. IDLE captures operands, RUN walks the
  // nibbles from LSB to MSB with the carry register as the only link between
  // nibbles, and DONE holds the published result until out_ready. The result
  // registers are written only on the RUN->DONE edge so they keep the last
  // result through IDLE and RUN. Leaving DONE never accepts new operands in
  // the same cycle. The counter stops at the last index rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      aOp_q      <= '0;
      bOp_q      <= '0;
      sumWork_q  <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            aOp_q   <= a;
            bOp_q   <= b;
            carry_q <= cin;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sumWork_q <= sumWork_d;
          carry_q   <= nibCout;
          if (count_q == LAST_IDX) begin
            sum_q      <= sumWork_d;
            cout_q     <= nibCout;
            overflow_q <= nibCout ^ carryIntoMsb;
            state_q    <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder with NIBBLES = 4. Expected
// results come from whole-word arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int LATENCY = NIBBLES;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks;
  int failures;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full-width unsigned sum for sum/cout, true signed sum
  // range check for overflow.
  function automatic void refModel(input logic [W-1:0] aV, input logic [W-1:0] bV,
                                   input logic cV, output logic [W-1:0] sV,
                                   output logic coV, output logic ovV);
    logic [W:0] full;
    int         signedSum;
    full      = {1'b0, aV} + {1'b0, bV} + {{W{1'b0}}, cV};
    sV        = full[W-1:0];
    coV       = full[W];
    signedSum = int'($signed(aV)) + int'($signed(bV)) + int'(cV);
    ovV       = (signedSum > 32767) || (signedSum < -32768);
  endfunction

  // Present operands once in_ready is seen and hold them across the accept edge.
  task automatic applyStimulus(input logic [W-1:0] aV, input logic [W-1:0] bV,
                               input logic cV, output bit accepted);
    int waitCycles;
    waitCycles = 0;
    while (!in_ready && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    accepted = in_ready;
    a        = aV;
    b        = bV;
    cin      = cV;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded.
  task automatic waitResult(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Hand the result to the consumer for one edge.
  task automatic takeResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_handshake in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs sum=%h cout=%b ov=%b required 0/0/0", sum, cout, overflow);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] vecA [6];
    logic [W-1:0] vecB [6];
    logic         vecC [6];
    logic [W-1:0] expS;
    logic         expC;
    logic         expO;
    bit           accepted;
    int           edges;
    vecA = '{16'h0033, 16'hFFFF, 16'h0B0B, 16'h7FFF, 16'h8000, 16'hFFFF};
    vecB = '{16'h0033, 16'h0000, 16'h0B0B, 16'h0001, 16'h8000, 16'hFFFF};
    vecC = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1};
    for (int i = 0; i < 6; i++) begin
      refModel(vecA[i], vecB[i], vecC[i], expS, expC, expO);
      applyStimulus(vecA[i], vecB[i], vecC[i], accepted);
      checks++;
      if (!accepted) begin
        failures++;
        $display("[TB] FAIL directed_accept vec=%0d in_ready never rose", i);
      end
      waitResult(edges);
      checks++;
      if (edges !== LATENCY) begin
        failures++;
        $display("[TB] FAIL directed_latency vec=%0d edges=%0d required %0d", i, edges, LATENCY);
      end
      checks++;
      if (sum !== expS || cout !== expC || overflow !== expO) begin
        failures++;
        $display("[TB] FAIL directed_result vec=%0d sum=%h cout=%b ov=%b required %h/%b/%b",
                 i, sum, cout, overflow, expS, expC, expO);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL directed_in_ready_done vec=%0d in_ready=%b required 0", i, in_ready);
      end
      takeResult();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL directed_release vec=%0d out_valid=%b in_ready=%b required 0/1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] expS;
    logic         expC;
    logic         expO;
    logic [W-1:0] newS;
    logic         newC;
    logic         newO;
    bit           accepted;
    int           edges;
    refModel(16'h1234, 16'h1111, 1'b0, expS, expC, expO);
    refModel(16'hA5A5, 16'h5A5B, 1'b1, newS, newC, newO);
    applyStimulus(16'h1234, 16'h1111, 1'b0, accepted);
    waitResult(edges);
    checks++;
    if (!accepted || edges !== LATENCY) begin
      failures++;
      $display("[TB] FAIL bp_first_op accepted=%0d edges=%0d required 1/%0d", accepted, edges, LATENCY);
    end
    a        = 16'hA5A5;
    b        = 16'h5A5B;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== expS || cout !== expC || overflow !== expO) begin
        failures++;
        $display("[TB] FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b sum=%h required 1/0/%h",
                 i, out_valid, in_ready, sum, expS);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== expS) begin
      failures++;
      $display("[TB] FAIL bp_release in_ready=%b out_valid=%b sum=%h required 1/0/%h",
               in_ready, out_valid, sum, expS);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_new_accept in_ready=%b required 0", in_ready);
    end
    waitResult(edges);
    checks++;
    if (edges !== LATENCY || sum !== newS || cout !== newC || overflow !== newO) begin
      failures++;
      $display("[TB] FAIL bp_new_result edges=%0d sum=%h cout=%b ov=%b required %0d/%h/%b/%b",
               edges, sum, cout, overflow, LATENCY, newS, newC, newO);
    end
    takeResult();
  endtask

  task automatic test_reset_mid_run();
    bit accepted;
    bit sawValid;
    applyStimulus(16'h4321, 16'h2222, 1'b1, accepted);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run in_ready=%b out_valid=%b sum=%h cout=%b ov=%b required 1/0/0/0/0",
               in_ready, out_valid, sum, cout, overflow);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_abort out_valid rose after abort, required no result");
    end
  endtask

  task automatic test_random();
    logic [W-1:0] rA;
    logic [W-1:0] rB;
    logic         rC;
    logic [W-1:0] expS;
    logic         expC;
    logic         expO;
    bit           accepted;
    int           edges;
    int           stall;
    for (int n = 0; n < 1000; n++) begin
      rA = W'($urandom);
      rB = W'($urandom);
      rC = 1'($urandom_range(0, 1));
      refModel(rA, rB, rC, expS, expC, expO);
      applyStimulus(rA, rB, rC, accepted);
      // Noise on the input side while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom_range(0, 1));
      waitResult(edges);
      checks++;
      if (!accepted || edges !== LATENCY) begin
        failures++;
        $display("[TB] FAIL rand_latency n=%0d accepted=%0d edges=%0d required 1/%0d",
                 n, accepted, edges, LATENCY);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b1 || sum !== expS || cout !== expC || overflow !== expO) begin
        failures++;
        $display("[TB] FAIL rand_result n=%0d a=%h b=%h cin=%b got valid=%b sum=%h cout=%b ov=%b required 1/%h/%b/%b",
                 n, rA, rB, rC, out_valid, sum, cout, overflow, expS, expC, expO);
      end
      in_valid = 1'b0;
      takeResult();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rand_duplicate n=%0d out_valid=%b required 0", n, out_valid);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 4, the number of 4-bit digits per operand (W = 4*NIBBLES, NIBBLES >= 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands a, b, cin present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  operand A, two's complement or unsigned.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry-in to the least significant nibble.
REQ-010 out_valid  output  1  sum, cout and overflow hold a valid result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  registered result a+b+cin mod 2^W.
REQ-013 cout  output  1  carry out of the most significant nibble.
REQ-014 overflow  output  1  signed overflow, the carry into the MSB XOR the carry out of the MSB.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, when in_valid=1, the block SHALL capture a, b and cin, clear the nibble counter, load the carry register with cin, and go to RUN.
REQ-018 In RUN, each cycle SHALL add nibble i of a and b plus the carry register in one 4-bit adder, write the 4-bit result into sum working register nibble i, load the adder carry-out into the carry register, and increment i (LSB nibble first).
REQ-019 After the nibble NIBBLES-1 cycle, the block SHALL load sum, cout and overflow from the working values and go to DONE.
REQ-020 The accept edge SHALL be followed by exactly NIBBLES RUN cycles, so that out_valid rises NIBBLES clock edges after the accept edge.
REQ-021 In DONE, sum, cout and overflow SHALL stay stable while out_ready=0.
REQ-022 When out_valid and out_ready are both 1, the block SHALL return to IDLE on that edge, with no same-cycle bypass to a new accept.
REQ-023 Operands presented while in_ready=0 SHALL be ignored and SHALL NOT corrupt the working registers.
REQ-024 sum, cout and overflow SHALL change only on the RUN->DONE edge or on reset, and SHALL hold the last result in IDLE and RUN.
REQ-025 The nibble counter SHALL be ceil(log2(NIBBLES)) bits wide and SHALL NOT wrap inside an operation.
REQ-026 All addition SHALL be modulo 2^4 per nibble, with the carry as the only inter-nibble path, and the W-bit result SHALL equal (a+b+cin) mod 2^W.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL go to IDLE and clear sum, cout, overflow, the carry register, the counter and the working registers to 0.
REQ-028 Reset SHALL take priority over every handshake, and an operation in RUN or DONE SHALL be aborted with no result produced.
REQ-029 The block SHALL drive in_ready=1 and out_valid=0 in the first cycle after reset deasserts.

Structure
REQ-030 The package nibble_adder_pkg SHALL hold the constant NIBBLE_W=4 and the FSM state enum typedef (IDLE, RUN, DONE).
REQ-031 The 4-bit add SHALL be one combinational sub-module, cla4, a carry-lookahead adder with ports a[3:0], b[3:0], cin, s[3:0] and cout, using internal propagate/generate terms.
REQ-032 cla4 SHALL be instantiated exactly once, and all sequencing SHALL stay in nibble_serial_adder.

Verification (NIBBLES=4)
REQ-033 Basic: a=0x0033, b=0x0033, cin=0 -> sum=0x0066, cout=0, overflow=0, with out_valid exactly 4 edges after accept.
REQ-034 Full ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, overflow=0; a=0x0B0B, b=0x0B0B, cin=0 -> sum=0x1616.
REQ-035 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs stable, in_ready=0, new operands ignored; then set out_ready=1 -> IDLE next edge, and the new operands are accepted on the following edge.
REQ-037 Reset mid-RUN: assert reset on the 2nd RUN cycle -> next cycle state is IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
REQ-038 Random: 1000 random a, b, cin with random out_ready stalls -> every result matches the (a+b+cin) reference model, and no result is lost or duplicated.
